// File: rtl/cache_ctrl_nway.sv
// N-way set-associative write-back / write-allocate cache between the CPU
// memory bus and a 16-bit burst SDRAM controller.
// Lines are filled and written back one halfword per RAM strobe.
// Each set keeps a round-robin victim pointer.
// A flush writes back every dirty line and then invalidates the whole cache.
module cache_ctrl_nway #(
  parameter int WAYS       = 4,
  parameter int SETS       = 16,
  parameter int LINE_BYTES = 256
) (
  input  logic                              cpu_clk,
  input  logic                              rst,
  input  logic [31:0]                       m_addr,
  input  logic [31:0]                       m_din,
  output logic [31:0]                       m_dout,
  input  logic [3:0]                        m_ctrl,
  input  logic                              m_rd,
  input  logic                              m_wr,
  input  logic                              m_flush,
  output logic                              m_bsy,
  output logic [15:0]                       ram_din_o,
  input  logic [15:0]                       ram_dout_i,
  output logic [31-$clog2(LINE_BYTES):0]    ram_addr_o,
  input  logic                              ram_get_i,
  input  logic                              ram_put_i,
  output logic                              ram_rd_o,
  output logic                              ram_wr_o
);

  localparam int OB  = $clog2(LINE_BYTES);
  localparam int SB  = $clog2(SETS);
  localparam int TB  = 32 - OB - SB;
  localparam int HW  = LINE_BYTES / 2;
  localparam int WPL = LINE_BYTES / 4;
  localparam int LB  = OB - 2;
  localparam int KB  = $clog2(HW);
  localparam int WB  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int NL  = WAYS * SETS;
  localparam int NLB = $clog2(NL);
  localparam int FB  = NLB + 1;
  localparam int DW  = $clog2(NL * WPL);

  typedef enum logic [2:0] {IDLE, LOOKUP, WBACK, FILL, FLUSH} state_t;

  state_t state, state_d;

  // Tag/state arrays, one entry per (way, set)
  logic [TB-1:0] tag_q   [NL];
  logic          valid_q [NL];
  logic          dirty_q [NL];
  logic [WB-1:0] ptr_q   [SETS];
  logic [31:0]   mem     [NL*WPL];

  // Latched request
  logic [TB-1:0] req_tag;
  logic [SB-1:0] req_set;
  logic [LB-1:0] req_word;
  logic [1:0]    req_bo;
  logic [31:0]   req_din;
  logic [3:0]    req_mask;
  logic          req_wr;

  // Burst / victim / flush bookkeeping
  logic [KB-1:0] cnt;
  logic [WB-1:0] vic_way;
  logic [SB-1:0] wb_set;
  logic          flushing;
  logic [FB-1:0] fl_idx;

  logic          hit, inv_found;
  logic [WB-1:0] hit_way, inv_way, miss_way;
  logic          vic_dirty;
  logic [WB-1:0] fl_way;
  logic [SB-1:0] fl_set;
  logic          fl_end, fl_dirty;
  logic          put_last, get_last;
  logic [31:0]   rd_word, wb_word;

  function automatic logic [NLB-1:0] lidx(input logic [WB-1:0] w, input logic [SB-1:0] s);
    return NLB'(int'(w) * SETS + int'(s));
  endfunction

  function automatic logic [DW-1:0] didx(input logic [WB-1:0] w, input logic [SB-1:0] s,
                                         input logic [LB-1:0] wd);
    return DW'((int'(w) * SETS + int'(s)) * WPL + int'(wd));
  endfunction

  // Tag compare and victim selection for the latched set
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[lidx(WB'(w), req_set)] && tag_q[lidx(WB'(w), req_set)] == req_tag) begin
        hit     = 1'b1;
        hit_way = WB'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[lidx(WB'(w), req_set)]) begin
        inv_found = 1'b1;
        inv_way   = WB'(w);
      end
    end
  end

  assign miss_way  = inv_found ? inv_way : ptr_q[req_set];
  assign vic_dirty = valid_q[lidx(miss_way, req_set)] & dirty_q[lidx(miss_way, req_set)];

  assign fl_way   = WB'(int'(fl_idx) % WAYS);
  assign fl_set   = SB'(int'(fl_idx) / WAYS);
  assign fl_end   = (fl_idx == FB'(NL));
  assign fl_dirty = valid_q[lidx(fl_way, fl_set)] & dirty_q[lidx(fl_way, fl_set)];

  assign put_last = (state == WBACK) && ram_put_i && (cnt == KB'(HW - 1));
  assign get_last = (state == FILL) && ram_get_i && (cnt == KB'(HW - 1));

  assign rd_word   = mem[didx(hit_way, req_set, req_word)];
  assign m_dout    = rd_word >> {req_bo, 3'b000};
  assign wb_word   = mem[didx(vic_way, wb_set, cnt[KB-1:1])];
  assign ram_din_o = cnt[0] ? wb_word[31:16] : wb_word[15:0];

  // State register
  always_ff @(posedge cpu_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d    = state;
    ram_rd_o   = 1'b0;
    ram_wr_o   = 1'b0;
    ram_addr_o = {req_tag, req_set};
    m_bsy      = rst | m_rd | m_wr | m_flush;
    case (state)
      IDLE: begin
        if (m_flush)          state_d = FLUSH;
        else if (m_rd | m_wr) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          state_d = IDLE;
          m_bsy   = rst;
        end else if (vic_dirty) begin
          state_d = WBACK;
        end else begin
          state_d = FILL;
        end
      end
      WBACK: begin
        ram_wr_o   = 1'b1;
        ram_addr_o = {tag_q[lidx(vic_way, wb_set)], wb_set};
        if (put_last) state_d = flushing ? FLUSH : FILL;
      end
      FILL: begin
        ram_rd_o = 1'b1;
        if (get_last) state_d = LOOKUP;
      end
      FLUSH: begin
        if (fl_end) begin
          state_d = IDLE;
          m_bsy   = rst;
        end else if (fl_dirty) begin
          state_d = WBACK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line state, victim pointers, burst counter and flush scan
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      cnt      <= '0;
      vic_way  <= '0;
      wb_set   <= '0;
      flushing <= 1'b0;
      fl_idx   <= '0;
      for (int i = 0; i < NL; i++) begin
        valid_q[i] <= 1'b0;
        dirty_q[i] <= 1'b0;
      end
      for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
    end else begin
      if ((state == WBACK && ram_put_i) || (state == FILL && ram_get_i)) cnt <= cnt + 1'b1;
      case (state)
        IDLE: begin
          if (m_flush) begin
            flushing <= 1'b1;
            fl_idx   <= '0;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (req_wr) dirty_q[lidx(hit_way, req_set)] <= 1'b1;
          end else begin
            vic_way <= miss_way;
            wb_set  <= req_set;
          end
        end
        WBACK: begin
          if (put_last) begin
            dirty_q[lidx(vic_way, wb_set)] <= 1'b0;
            if (flushing) fl_idx <= fl_idx + 1'b1;
          end
        end
        FILL: begin
          if (get_last) begin
            valid_q[lidx(vic_way, req_set)] <= 1'b1;
            dirty_q[lidx(vic_way, req_set)] <= 1'b0;
            ptr_q[req_set] <= (int'(ptr_q[req_set]) == WAYS - 1) ? '0 : ptr_q[req_set] + 1'b1;
          end
        end
        FLUSH: begin
          if (fl_end) begin
            flushing <= 1'b0;
            for (int i = 0; i < NL; i++) begin
              valid_q[i] <= 1'b0;
              dirty_q[i] <= 1'b0;
            end
          end else if (fl_dirty) begin
            vic_way <= fl_way;
            wb_set  <= fl_set;
          end else begin
            fl_idx <= fl_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Request capture, data array writes and tag install (storage is not reset)
  always_ff @(posedge cpu_clk) begin
    if (state == IDLE) begin
      req_tag  <= m_addr[31:OB+SB];
      req_set  <= m_addr[OB+SB-1:OB];
      req_word <= m_addr[OB-1:2];
      req_bo   <= m_addr[1:0];
      req_din  <= m_din;
      req_mask <= m_ctrl;
      req_wr   <= m_wr;
    end
    if (state == LOOKUP && hit && req_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (req_mask[b]) mem[didx(hit_way, req_set, req_word)][8*b +: 8] <= req_din[8*b +: 8];
      end
    end
    if (state == FILL && ram_get_i) begin
      if (cnt[0]) mem[didx(vic_way, req_set, cnt[KB-1:1])][31:16] <= ram_dout_i;
      else        mem[didx(vic_way, req_set, cnt[KB-1:1])][15:0]  <= ram_dout_i;
      if (get_last) tag_q[lidx(vic_way, req_set)] <= req_tag;
    end
  end

endmodule

// File: doc/cache_ctrl_nway.md
# cache_ctrl_nway

Parametrised write-back, write-allocate, N-way set-associative cache between the CPU memory bus and the 16-bit burst SDRAM controller, running on a single clock. Over the fixed 4-way/16-set/256-byte controller it adds configurable geometry, per-line valid bits, a per-set round-robin victim pointer, and a whole-cache flush (write back and invalidate). It keeps the CPU busy/ready handshake and the RAM get/put strobe protocol unchanged.

## Interface
- WAYS, 4, associativity; power of two, 1..8
- SETS, 16, sets per way; power of two, 2..256
- LINE_BYTES, 256, line size in bytes; power of two, 16..1024
- Derived: OB = log2(LINE_BYTES), SB = log2(SETS), TB = 32-OB-SB, HW = LINE_BYTES/2 halfwords per burst
- cpu_clk  in  1  sole clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- m_addr  in  32  byte address
- m_din  in  32  write data (lanes not shifted)
- m_dout  out  32  read data
- m_ctrl  in  4  byte-lane write mask
- m_rd  in  1  read request, held until accepted
- m_wr  in  1  write request, held until accepted
- m_flush  in  1  flush request, held until accepted
- m_bsy  out  1  transaction not complete
- ram_din_o  out  16  write-back halfword
- ram_dout_i  in  16  fill halfword
- ram_addr_o  out  32-OB  line address, {tag,set}
- ram_get_i  in  1  fill halfword strobe
- ram_put_i  in  1  write-back halfword strobe
- ram_rd_o  out  1  fill burst request
- ram_wr_o  out  1  write-back burst request

## Operation
- Address split: tag = addr[31:OB+SB], set = addr[OB+SB-1:OB], word = addr[OB-1:2].
- States: IDLE, LOOKUP, WBACK, FILL, FLUSH.
- IDLE: m_flush → FLUSH (takes priority over a simultaneous m_rd/m_wr). m_rd|m_wr → latch address/data/mask, read the data array → LOOKUP.
- LOOKUP: a hit is a valid way with a matching tag; no two valid ways in one set hold the same tag.
  - On a hit, m_bsy=0 this cycle.
  - Read: m_dout = line word >> (8·addr[1:0]); misalignment is not otherwise handled.
  - Write: the bytes set in m_ctrl are written at the closing edge; dirty is set.
  - Next state is IDLE.
- Miss, victim choice: the lowest-index invalid way; if every way is valid, the set's round-robin pointer.
  - Victim valid and dirty → WBACK; otherwise → FILL.
- WBACK: ram_addr_o = {victim tag, set}; ram_wr_o=1.
  - ram_din_o carries halfword k (bytes 2k+1:2k, little-endian), where k counts ram_put_i pulses.
  - After HW puts: ram_wr_o=0 and the victim's dirty bit is cleared → FILL.
- FILL: ram_addr_o = {tag, set}; ram_rd_o=1.
  - Get pulse k writes ram_dout_i into halfword k of the victim way.
  - After HW gets: ram_rd_o=0; tag installed; valid=1, dirty=0; the set's pointer increments modulo WAYS → LOOKUP. The re-lookup hits, so a write miss merges normally.
- FLUSH: scan every (set, way) in order, set 0 way 0 first. Each valid dirty line gets a WBACK burst.
  - At the end, all valid and dirty bits clear → IDLE with m_bsy=0 for one cycle, acknowledging m_flush.
- m_bsy = (m_rd|m_wr|m_flush) & ~(hit completion or flush completion this cycle). m_bsy=1 while rst.
- Reset: FSM goes to IDLE; all valid, dirty and pointer state clears; ram_rd_o=ram_wr_o=0; counters clear. Data array contents need not clear.
- Reset during a burst: strobes drop at the next edge and no line is installed. The RAM controller aborts on the deasserted request.

## Timing
- Hit: request visible in cycle 0 (m_bsy=1); m_bsy=0 with valid m_dout in cycle 1; accepted at the end of cycle 1. Back-to-back hits: 2 cycles each.
- Miss, clean victim: 2 + FILL burst + 1 (LOOKUP) cycles.
- Miss, dirty victim: WBACK burst is added before FILL.
- ram_rd_o/ram_wr_o assert the cycle after the LOOKUP miss and stay high until the edge on which the HW-th strobe is seen.
- RAM-side guarantees:
  - Puts are at least 2 cycles apart.
  - The first put is no earlier than the 2nd cycle of ram_wr_o.
  - ram_din_o is valid by then and is updated one cycle after each put.
- Get and put never coincide.
- Strobes outside a burst are ignored.

## Test plan
- Reset, then read 0x00000104. RAM returns halfword value k on get k. Expect: ram_rd_o with ram_addr_o=0x000001; 128 gets; m_dout=0x00030002.
- Read 0x00000104 again. Expect: m_bsy high 1 cycle, no RAM activity, same data.
- Read 0x00000106. Expect: m_dout=0x00000003.
- Write 0xDEADBEEF, m_ctrl=4'b0011, to 0x104; then read it. Expect: 0x0003BEEF.
- Read lines 0x01100, 0x02100, 0x03100 after the dirty 0x00100; then read 0x04100. Expect: the write-back burst at 0x000001 (ram_din_o halfword 2 = 0xBEEF), then a fill at 0x000041; the set-1 pointer moves to 1.
- Dirty 2 lines, assert m_flush. Expect: exactly 2 write-back bursts in set/way order, then every read misses.
- Assert rst at get 40 of a fill. Expect: ram_rd_o=0 next cycle; re-reading that address misses and fills fully.
